// File: rtl/sync_ram_pkg.sv
// Shared types and constants for the sync_ram memory block.
// Both the top-level FSM and the storage core import this package.
package sync_ram_pkg;

  typedef enum logic {
    CLEAR,
    IDLE
  } ram_state_t;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

endpackage

// File: rtl/sync_ram_core.sv
// Storage array with one synchronous write port and one registered read port.
// The READ_MODE bypass selects old or new data for a same-address read/write.
module ram_core
  import sync_ram_pkg::*;
#(
  parameter int WORD      = 1,
  parameter int SIZE_LOG  = 8,
  parameter int READ_MODE = READ_FIRST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [SIZE_LOG-1:0] waddr,
  input  logic [WORD-1:0]     wdata,
  input  logic                re,
  input  logic [SIZE_LOG-1:0] raddr,
  output logic [WORD-1:0]     rdata
);

  localparam int SIZE = 2 ** SIZE_LOG;

  logic [WORD-1:0] mem [SIZE];
  logic            bypass;

  assign bypass = (READ_MODE == WRITE_FIRST) && we && (waddr == raddr);

  // NOTE: the array has no reset; zeroing is done by the sweep so it maps to RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-first falls out of the non-blocking update: mem[raddr] is still the old word.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= bypass ? wdata : mem[raddr];
  end

endmodule

// File: rtl/sync_ram.sv
// Synchronous RAM with registered read, valid strobe and a hardware clear sweep.
// The FSM owns the write port during CLEAR and blocks user access while busy.
module sync_ram
  import sync_ram_pkg::*;
#(
  parameter int WORD      = 1,
  parameter int SIZE_LOG  = 8,
  parameter int READ_MODE = READ_FIRST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                read,
  input  logic                write,
  input  logic [SIZE_LOG-1:0] address,
  input  logic [WORD-1:0]     data_in,
  output logic [WORD-1:0]     data_out,
  output logic                data_valid,
  output logic                busy
);

  localparam int SIZE = 2 ** SIZE_LOG;

  ram_state_t          state;
  logic [SIZE_LOG-1:0] ptr;
  logic                mem_we;
  logic                mem_re;
  logic [SIZE_LOG-1:0] mem_waddr;
  logic [WORD-1:0]     mem_wdata;

  assign busy = (state == CLEAR);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = address;
    mem_wdata = data_in;
    if (!reset) begin
      if (busy) begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = '0;
      end else begin
        mem_we = write;
        mem_re = read;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      ptr        <= '0;
      data_valid <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          data_valid <= 1'b0;
          ptr        <= ptr + 1'b1;
          if (ptr == {SIZE_LOG{1'b1}}) state <= IDLE;
        end
        IDLE: begin
          data_valid <= read;
          if (clear) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  ram_core #(
    .WORD      (WORD),
    .SIZE_LOG  (SIZE_LOG),
    .READ_MODE (READ_MODE)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (address),
    .rdata (data_out)
  );

  // SIZE is kept for readers of the sweep length; the terminal test is ptr=='1.
  logic unused_size;
  assign unused_size = (SIZE > 0);

endmodule

// File: tb/tb_sync_ram.sv
// Self-checking bench for sync_ram: read-first and write-first 16x8 instances
// share stimulus; a 2x1 instance covers the width edge.
module tb_sync_ram;

  logic       clk = 1'b0;
  logic       reset = 1'b0, clear = 1'b0, read = 1'b0, write = 1'b0;
  logic [3:0] address = '0;
  logic [7:0] data_in = '0;
  logic [7:0] dout0, dout1;
  logic       dv0, dv1, busy0, busy1;

  logic reset2 = 1'b0, clear2 = 1'b0, read2 = 1'b0, write2 = 1'b0;
  logic address2 = 1'b0, data_in2 = 1'b0;
  logic dout2, dv2, busy2;

  always #5 clk = ~clk;

  sync_ram #(.WORD(8), .SIZE_LOG(4), .READ_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .read(read), .write(write),
    .address(address), .data_in(data_in),
    .data_out(dout0), .data_valid(dv0), .busy(busy0));

  sync_ram #(.WORD(8), .SIZE_LOG(4), .READ_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .read(read), .write(write),
    .address(address), .data_in(data_in),
    .data_out(dout1), .data_valid(dv1), .busy(busy1));

  sync_ram #(.WORD(1), .SIZE_LOG(1), .READ_MODE(0)) dut2 (
    .clk(clk), .reset(reset2), .clear(clear2), .read(read2), .write(write2),
    .address(address2), .data_in(data_in2),
    .data_out(dout2), .data_valid(dv2), .busy(busy2));

  int tests = 0;
  int fails = 0;

  // Reference model: memory contents, remaining busy cycles, expected outputs.
  logic [7:0] m_mem [16];
  int         m_busy_left = 0;
  logic       m_dv = 1'b0;
  logic [7:0] m_dout0 = '0, m_dout1 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic clr, input logic rd, input logic wr,
                      input logic [3:0] a, input logic [7:0] d);
    reset = rst; clear = clr; read = rd; write = wr; address = a; data_in = d;
    @(posedge clk);
    if (rst) begin
      m_busy_left = 16;
      m_dv = 1'b0; m_dout0 = '0; m_dout1 = '0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      m_dv = 1'b0;
      if (m_busy_left == 0) for (int i = 0; i < 16; i++) m_mem[i] = '0;
    end else begin
      m_dv = rd;
      if (rd) begin
        m_dout0 = m_mem[a];
        m_dout1 = wr ? d : m_mem[a];
      end
      if (wr) m_mem[a] = d;
      if (clr) m_busy_left = 16;
    end
    #1;
    check("busy_rf", busy0, m_busy_left > 0);
    check("busy_wf", busy1, m_busy_left > 0);
    check("valid_rf", dv0, m_dv);
    check("valid_wf", dv1, m_dv);
    check("dout_rf", dout0, m_dout0);
    check("dout_wf", dout1, m_dout1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
  endtask

  // Count busy samples from a just-started sweep, hammering addr 2 meanwhile.
  task automatic count_sweep(output int n);
    n = busy0 ? 1 : 0;
    while (busy0 && n < 40) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 8'hFF);
      if (busy0) n++;
    end
  endtask

  task automatic step2(input logic rst, input logic rd, input logic wr,
                       input logic a, input logic d);
    reset2 = rst; read2 = rd; write2 = wr; address2 = a; data_in2 = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [3:0] ra;
    logic [7:0] rd_data;
    logic r_rd, r_wr, r_clr, r_rst;

    // Reset sweep with blocked access during it.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    check("reset_busy", busy0, 1'b1);
    check("reset_valid", dv0, 1'b0);
    check("reset_dout", dout0, 8'h00);
    count_sweep(n);
    check("reset_sweep_len", n, 16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'(i), 8'd0);
      check("zero_after_reset", dout0, 8'h00);
      check("zero_valid", dv0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 8'd0);
    check("blocked_addr2", dout0, 8'h00);

    // Write then read, then an idle cycle holding data.
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 8'hA5);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
    check("wr_rd_data", dout0, 8'hA5);
    check("wr_rd_valid", dv0, 1'b1);
    idle();
    check("hold_valid", dv0, 1'b0);
    check("hold_data", dout0, 8'hA5);

    // Read-during-write at the same address.
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 8'h11);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 8'h22);
    check("rdw_read_first", dout0, 8'h11);
    check("rdw_write_first", dout1, 8'h22);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
    check("rdw_later_rf", dout0, 8'h22);
    check("rdw_later_wf", dout1, 8'h22);

    // Randomized traffic against the model, occasional clear and reset.
    for (int i = 0; i < 400; i++) begin
      ra = 4'($urandom);
      rd_data = 8'($urandom);
      r_rd = 1'($urandom);
      r_wr = 1'($urandom);
      r_clr = ($urandom_range(0, 39) == 0);
      r_rst = ($urandom_range(0, 149) == 0);
      step(r_rst, r_clr, r_rd, r_wr, ra, rd_data);
    end
    while (busy0 && n < 200) begin idle(); n++; end

    // Fill then clear; busy rises next cycle and all reads return zero.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 8'(8'h30 + i));
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    check("clear_busy_rise", busy0, 1'b1);
    count_sweep(n);
    check("clear_sweep_len", n, 16);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'(i), 8'd0);
      check("zero_after_clear", dout0, 8'h00);
    end

    // Reset at sweep cycle 7 restarts a full sweep.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    for (int i = 0; i < 6; i++) idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    count_sweep(n);
    check("restart_sweep_len", n, 16);

    // Width edge: 1-bit words, 2 locations.
    step2(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("w1_reset_busy", busy2, 1'b1);
    check("w1_reset_dout", dout2, 1'b0);
    n = 1;
    while (busy2 && n < 10) begin
      step2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (busy2) n++;
    end
    check("w1_sweep_len", n, 2);
    step2(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step2(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("w1_addr0", dout2, 1'b0);
    check("w1_addr0_valid", dv2, 1'b1);
    step2(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("w1_addr1", dout2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_ram.md
Name: sync_ram

Overview:
- Synchronous, parametrised read/write memory; successor to the latch-based 1-bit program/data store of the MC14500B system.
- Provides a registered read port with a valid strobe and a selectable read-during-write policy.
- Includes a hardware clear sweep that zeroes every location after reset or on request, with a busy flag to the ICU/sequencer.
- Sits between the MC14500B control unit and its program/IO storage.

Parameters:
- WORD, 1, data width in bits (>=1).
- SIZE_LOG, 8, address width in bits (>=1).
- SIZE, 2**SIZE_LOG, number of locations; derived, not overridden.
- READ_MODE, 0, read policy for a read and write to the same address in the same cycle: 0 = read-first (old data), 1 = write-first (new data).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  request a full zeroing sweep; sampled in IDLE only.
- read  in  1  read request; sampled when busy=0.
- write  in  1  write request; sampled when busy=0.
- address  in  SIZE_LOG  location for read and/or write.
- data_in  in  WORD  write data.
- data_out  out  WORD  registered read data; holds its value between reads.
- data_valid  out  1  one-cycle pulse, asserted the cycle after an accepted read.
- busy  out  1  high while the clear sweep runs; read and write are ignored.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=CLEAR, sweep pointer=0.
  - data_out='0, data_valid=0, busy=1.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- FSM states:
  - CLEAR: each cycle writes '0 to mem[ptr], then ptr++. The cycle that writes ptr==SIZE-1 moves to IDLE. The sweep therefore takes exactly SIZE cycles, and busy falls on the edge that completes it.
  - IDLE: serves read and write requests. If clear=1, go to CLEAR with ptr=0 and busy=1 on the next cycle. Any read or write in that same cycle is still executed.
- busy = (state==CLEAR). In CLEAR the read, write and clear inputs are ignored: no memory change, data_valid=0, data_out held.
- Write (IDLE, write=1): mem[address] <= data_in at the clock edge. Write latency is 1 cycle.
- Read (IDLE, read=1): data_out <= mem[address] and data_valid <= 1 at the next edge. Read latency is 1 cycle. Otherwise data_valid <= 0 and data_out holds its value.
- Read and write to the same address in the same cycle:
  - READ_MODE=0: data_out = previous content.
  - READ_MODE=1: data_out = data_in.
  - Memory gets data_in in both modes.
- Read and write to different addresses in the same cycle are independent.
- The sweep pointer is SIZE_LOG bits wide; terminal detection is ptr=='1, so there is no wrap. The pointer is not observable.
- The memory array has no initial-block contents; zero state comes only from the sweep.
- No X on outputs after reset. The X-state of the array before the first sweep is not visible, because reads are blocked while busy.

Decomposition:
- Package sync_ram_pkg:
  - enum ram_state_t {CLEAR, IDLE}.
  - localparams READ_FIRST=0 and WRITE_FIRST=1 for READ_MODE.
- Sub-module ram_core(WORD, SIZE_LOG): storage array with one synchronous write port and one registered read port, plus the READ_MODE bypass mux.
- The top level holds the FSM, the sweep pointer, the write-port mux (sweep vs user) and the data_valid register.

Test Plan:
- Reset sweep: SIZE_LOG=4, pulse reset 1 cycle -> busy=1 for exactly 16 cycles, then 0. A subsequent read of all 16 addresses returns 0 with data_valid pulsing each following cycle.
- Write then read: WORD=8; write 0xA5 to addr 3; next cycle read addr 3 -> one cycle later data_out=0xA5, data_valid=1. The following idle cycle gives data_valid=0 with data_out still 0xA5.
- Read-during-write: addr 5 holds 0x11; same cycle write 0x22 and read addr 5.
  - READ_MODE=0 -> data_out=0x11.
  - READ_MODE=1 -> data_out=0x22.
  - A later read returns 0x22 in both cases.
- Blocked access: during the sweep, write 0xFF to addr 2 and read addr 2 -> data_valid stays 0 and data_out is unchanged. After busy falls, addr 2 reads 0.
- Clear and reset mid-operation:
  - Fill addr 0..3 with nonzero values, assert clear -> busy rises next cycle; after SIZE cycles all addresses read 0.
  - Reset asserted at sweep cycle 7 -> busy lasts a full SIZE cycles counted from the reset.
- Width edge: WORD=1, SIZE_LOG=1 -> sweep of 2 cycles; write 1 to addr 1; read addr 0 returns 0 and addr 1 returns 1.
